// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions: prefix bytes, prefix-decoder states and
// flag modes used by the key-watching logic.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_e;

  localparam int MODE_STICKY = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_LEVEL  = 2;

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Tracks E0/F0 prefixes in the scancode stream and flags each completed
// make/break event in the same cycle its final byte arrives.
module ps2_prefix_fsm
  import ps2_pkg::*;
#(
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] tecla,
  input  logic              got_data,
  output logic              event_valid,
  output logic              is_break,
  output logic              is_ext,
  output logic [CODE_W-1:0] code
);

  localparam logic [CODE_W-1:0] BRK_CODE = CODE_W'(PS2_BREAK);
  localparam logic [CODE_W-1:0] EXT_CODE = CODE_W'(PS2_EXT);

  prefix_state_e state_q, state_d;

  assign code = tecla;

  // Event flags are decoded from the current state and byte so the channel
  // registers can act on them at the very next edge.
  always_comb begin
    state_d     = state_q;
    event_valid = 1'b0;
    is_break    = 1'b0;
    is_ext      = 1'b0;
    if (got_data) begin
      unique case (state_q)
        IDLE: begin
          if (tecla == BRK_CODE) begin
            state_d = BRK;
          end else if (tecla == EXT_CODE) begin
            state_d = EXT;
          end else begin
            event_valid = 1'b1;
          end
        end
        EXT: begin
          if (tecla == BRK_CODE) begin
            state_d = EXT_BRK;
          end else if (tecla == EXT_CODE) begin
            state_d = EXT;
          end else begin
            event_valid = 1'b1;
            is_ext      = 1'b1;
            state_d     = IDLE;
          end
        end
        BRK: begin
          event_valid = 1'b1;
          is_break    = 1'b1;
          state_d     = IDLE;
        end
        EXT_BRK: begin
          event_valid = 1'b1;
          is_break    = 1'b1;
          is_ext      = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/senal_teclas_multi.sv
// Multi-key flag generator: watches the PS/2 scancode stream for NUM_KEYS
// keycodes and drives one sticky/toggle/level flag per key.
module senal_teclas_multi
  import ps2_pkg::*;
#(
  parameter int                           NUM_KEYS   = 4,
  parameter int                           CODE_W     = 8,
  parameter logic [NUM_KEYS*CODE_W-1:0]   KEY_CODES  = {8'h7A, 8'h72, 8'h69, 8'h70},
  parameter int                           MODE       = 0,
  parameter int                           ACCEPT_EXT = 0,
  localparam int                          LK_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CODE_W-1:0]   tecla,
  input  logic                got_data,
  input  logic [NUM_KEYS-1:0] clr,
  output logic [NUM_KEYS-1:0] senal,
  output logic [NUM_KEYS-1:0] senal_rise,
  output logic                any_senal,
  output logic [LK_W-1:0]     last_key
);

  logic              ev_valid;
  logic              ev_break;
  logic              ev_ext;
  logic [CODE_W-1:0] ev_code;

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] make_eff;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] senal_q, senal_d;
  logic [NUM_KEYS-1:0] rise_q;
  logic [LK_W-1:0]     last_q, last_d;

  ps2_prefix_fsm #(
    .CODE_W(CODE_W)
  ) u_prefix (
    .clk        (clk),
    .reset_n    (reset_n),
    .tecla      (tecla),
    .got_data   (got_data),
    .event_valid(ev_valid),
    .is_break   (ev_break),
    .is_ext     (ev_ext),
    .code       (ev_code)
  );

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    logic held_nx;
    logic senal_nx;
    logic mk;
    logic bk;

    assign match[g]    = ev_valid && (ev_code == KEY_CODES[g*CODE_W +: CODE_W]) &&
                         (!ev_ext || (ACCEPT_EXT != 0));
    assign mk          = match[g] && !ev_break;
    assign bk          = match[g] && ev_break;
    assign make_eff[g] = mk && !clr[g];

    // clr wins over any event on this channel; held distinguishes a fresh
    // make from a typematic repeat.
    always_comb begin
      held_nx  = held_q[g];
      senal_nx = senal_q[g];
      if (clr[g]) begin
        held_nx  = 1'b0;
        senal_nx = 1'b0;
      end else begin
        if (mk) begin
          held_nx = 1'b1;
        end else if (bk) begin
          held_nx = 1'b0;
        end
        if (MODE == MODE_TOGGLE) begin
          if (mk && !held_q[g]) begin
            senal_nx = ~senal_q[g];
          end
        end else if (MODE == MODE_LEVEL) begin
          senal_nx = held_nx;
        end else begin
          if (mk) begin
            senal_nx = 1'b1;
          end
        end
      end
    end

    assign held_d[g]  = held_nx;
    assign senal_d[g] = senal_nx;
  end

  // Downward scan so the lowest matching channel is the one recorded.
  always_comb begin
    last_d = last_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (make_eff[i]) begin
        last_d = LK_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q  <= '0;
      senal_q <= '0;
      rise_q  <= '0;
      last_q  <= '0;
    end else begin
      held_q  <= held_d;
      senal_q <= senal_d;
      rise_q  <= senal_d & ~senal_q;
      last_q  <= last_d;
    end
  end

  assign senal      = senal_q;
  assign senal_rise = rise_q;
  assign any_senal  = |senal_q;
  assign last_key   = last_q;

endmodule

// File: tb/tb_senal_teclas_multi.sv
// Bench for senal_teclas_multi: four configurations share one byte stream
// and are compared each cycle against a flag-level behavioural model.
module tb_senal_teclas_multi;

  logic       clk;
  logic       reset_n;
  logic [7:0] tecla;
  logic       got_data;
  logic [3:0] clr;

  logic [3:0] senal_o [4];
  logic [3:0] rise_o  [4];
  logic       any_o   [4];
  logic [1:0] last_o  [4];

  int checks;
  int failures;

  // config k: dut0 sticky, dut1 toggle, dut2 level, dut3 sticky + extended accepted
  senal_teclas_multi #(.MODE(0), .ACCEPT_EXT(0)) u_d0 (
    .clk(clk), .reset_n(reset_n), .tecla(tecla), .got_data(got_data), .clr(clr),
    .senal(senal_o[0]), .senal_rise(rise_o[0]), .any_senal(any_o[0]), .last_key(last_o[0]));
  senal_teclas_multi #(.MODE(1), .ACCEPT_EXT(0)) u_d1 (
    .clk(clk), .reset_n(reset_n), .tecla(tecla), .got_data(got_data), .clr(clr),
    .senal(senal_o[1]), .senal_rise(rise_o[1]), .any_senal(any_o[1]), .last_key(last_o[1]));
  senal_teclas_multi #(.MODE(2), .ACCEPT_EXT(0)) u_d2 (
    .clk(clk), .reset_n(reset_n), .tecla(tecla), .got_data(got_data), .clr(clr),
    .senal(senal_o[2]), .senal_rise(rise_o[2]), .any_senal(any_o[2]), .last_key(last_o[2]));
  senal_teclas_multi #(.MODE(0), .ACCEPT_EXT(1)) u_d3 (
    .clk(clk), .reset_n(reset_n), .tecla(tecla), .got_data(got_data), .clr(clr),
    .senal(senal_o[3]), .senal_rise(rise_o[3]), .any_senal(any_o[3]), .last_key(last_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending-prefix flags and per-key flag state
  bit         m_pend_ext [4];
  bit         m_pend_brk [4];
  logic [3:0] m_held     [4];
  logic [3:0] m_sen      [4];
  logic [3:0] m_rise     [4];
  logic [1:0] m_last     [4];
  logic [7:0] kc         [4];

  function automatic int mode_of(input int k);
    return (k == 3) ? 0 : k;
  endfunction

  function automatic bit acc_of(input int k);
    return (k == 3);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pend_ext[k] = 0;
      m_pend_brk[k] = 0;
      m_held[k]     = '0;
      m_sen[k]      = '0;
      m_rise[k]     = '0;
      m_last[k]     = '0;
    end
  endtask

  task automatic model_step(input logic gd, input logic [7:0] b, input logic [3:0] c);
    for (int k = 0; k < 4; k++) begin
      bit         ev;
      bit         evb;
      bit         eve;
      bit         found;
      bit         hit;
      logic [3:0] ns;
      logic [3:0] nh;
      ev = 0; evb = 0; eve = 0; found = 0;
      if (gd) begin
        if (m_pend_brk[k]) begin
          ev = 1; evb = 1; eve = m_pend_ext[k];
          m_pend_brk[k] = 0; m_pend_ext[k] = 0;
        end else if (b == 8'hF0) begin
          m_pend_brk[k] = 1;
        end else if (b == 8'hE0) begin
          m_pend_ext[k] = 1;
        end else begin
          ev = 1; eve = m_pend_ext[k];
          m_pend_ext[k] = 0;
        end
      end
      ns = m_sen[k];
      nh = m_held[k];
      for (int i = 0; i < 4; i++) begin
        hit = ev && (b == kc[i]) && (!eve || acc_of(k));
        if (c[i]) begin
          nh[i] = 1'b0;
          ns[i] = 1'b0;
        end else if (hit && !evb) begin
          nh[i] = 1'b1;
          case (mode_of(k))
            0: ns[i] = 1'b1;
            1: if (!m_held[k][i]) ns[i] = ~m_sen[k][i];
            default: ns[i] = 1'b1;
          endcase
          if (!found) begin
            m_last[k] = 2'(i);
            found = 1;
          end
        end else if (hit && evb) begin
          nh[i] = 1'b0;
          if (mode_of(k) == 2) ns[i] = 1'b0;
        end
      end
      m_rise[k] = ns & ~m_sen[k];
      m_sen[k]  = ns;
      m_held[k] = nh;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk("senal", k, 32'(senal_o[k]), 32'(m_sen[k]));
      chk("senal_rise", k, 32'(rise_o[k]), 32'(m_rise[k]));
      chk("any_senal", k, 32'(any_o[k]), 32'(|m_sen[k]));
      chk("last_key", k, 32'(last_o[k]), 32'(m_last[k]));
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge and sampled 1 after the next.
  task automatic cycle(input logic gd, input logic [7:0] b, input logic [3:0] c);
    got_data = gd;
    tecla    = b;
    clr      = c;
    @(posedge clk);
    model_step(gd, b, c);
    #1;
    got_data = 1'b0;
    clr      = 4'b0000;
    tecla    = 8'($urandom);
    check_all();
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 7))
      0: return 8'h70;
      1: return 8'h69;
      2: return 8'h72;
      3: return 8'h7A;
      4: return 8'hE0;
      5: return 8'hF0;
      6: return 8'h70;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    kc[0] = 8'h70; kc[1] = 8'h69; kc[2] = 8'h72; kc[3] = 8'h7A;
    reset_n  = 1'b0;
    got_data = 1'b0;
    tecla    = 8'h00;
    clr      = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // sticky: make, break, clear
    cycle(1'b1, 8'h70, 4'b0000);
    chk("stk_make_senal", 0, 32'(senal_o[0]), 32'h1);
    chk("stk_make_rise", 0, 32'(rise_o[0]), 32'h1);
    chk("stk_make_last", 0, 32'(last_o[0]), 32'h0);
    cycle(1'b0, 8'h00, 4'b0000);
    chk("stk_rise_once", 0, 32'(rise_o[0]), 32'h0);
    cycle(1'b1, 8'hF0, 4'b0000);
    cycle(1'b1, 8'h70, 4'b0000);
    chk("stk_break_hold", 0, 32'(senal_o[0]), 32'h1);
    cycle(1'b0, 8'h00, 4'b0001);
    chk("stk_clr", 0, 32'(senal_o[0]), 32'h0);

    // toggle with typematic repeats
    cycle(1'b0, 8'h00, 4'b1111);
    cycle(1'b1, 8'h69, 4'b0000);
    chk("tgl_first", 1, 32'(senal_o[1][1]), 32'h1);
    chk("tgl_last_key", 1, 32'(last_o[1]), 32'h1);
    cycle(1'b1, 8'h69, 4'b0000);
    cycle(1'b1, 8'h69, 4'b0000);
    chk("tgl_repeat", 1, 32'(senal_o[1][1]), 32'h1);
    cycle(1'b1, 8'hF0, 4'b0000);
    cycle(1'b1, 8'h69, 4'b0000);
    chk("tgl_break", 1, 32'(senal_o[1][1]), 32'h1);
    cycle(1'b1, 8'h69, 4'b0000);
    chk("tgl_second", 1, 32'(senal_o[1][1]), 32'h0);

    // level, with an extended code ignored
    cycle(1'b0, 8'h00, 4'b1111);
    cycle(1'b1, 8'h72, 4'b0000);
    chk("lvl_make", 2, 32'(senal_o[2]), 32'h4);
    cycle(1'b1, 8'hE0, 4'b0000);
    cycle(1'b1, 8'h72, 4'b0000);
    chk("lvl_ext_ignored", 2, 32'(senal_o[2]), 32'h4);
    cycle(1'b1, 8'hF0, 4'b0000);
    cycle(1'b1, 8'h72, 4'b0000);
    chk("lvl_break", 2, 32'(senal_o[2]), 32'h0);

    // extended filtering, then the next plain byte is a make
    cycle(1'b0, 8'h00, 4'b1111);
    cycle(1'b1, 8'hE0, 4'b0000);
    cycle(1'b1, 8'h7A, 4'b0000);
    chk("ext_reject", 0, 32'(senal_o[0]), 32'h0);
    chk("ext_accept", 3, 32'(senal_o[3]), 32'h8);
    cycle(1'b1, 8'h70, 4'b0000);
    chk("ext_back_idle", 0, 32'(senal_o[0]), 32'h1);

    // clear versus event in the same cycle
    cycle(1'b0, 8'h00, 4'b1111);
    cycle(1'b1, 8'h70, 4'b0001);
    chk("col_same_senal", 0, 32'(senal_o[0]), 32'h0);
    chk("col_same_rise", 0, 32'(rise_o[0]), 32'h0);
    cycle(1'b1, 8'h70, 4'b0010);
    chk("col_other", 0, 32'(senal_o[0][0]), 32'h1);

    // asynchronous reset between F0 and the code byte
    cycle(1'b1, 8'hF0, 4'b0000);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("arst_senal", k, 32'(senal_o[k]), 32'h0);
      chk("arst_rise", k, 32'(rise_o[k]), 32'h0);
      chk("arst_last", k, 32'(last_o[k]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h70, 4'b0000);
    chk("arst_make", 0, 32'(senal_o[0]), 32'h1);

    // randomized stream against the model
    for (int n = 0; n < 3000; n++) begin
      logic       gd;
      logic [3:0] c;
      gd = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      cycle(gd, pick_byte(), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
